// File: rtl/quad_align_pkg.sv
// Shared types and helpers for the four-channel stream aligner.
// Channel beats carry 16 x 16-bit samples plus the channel's end-of-frame bit.
package quad_align_pkg;

  localparam int NUM_CH        = 4;
  localparam int SAMPLE_WIDTH  = 16;
  localparam int CH_DATA_WIDTH = 16 * SAMPLE_WIDTH;

  typedef struct packed {
    logic                     tlast;
    logic [CH_DATA_WIDTH-1:0] tdata;
  } ch_beat_t;

  // Ceiling log2 for sizing pointers and counters at elaboration time.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with an extra wrap bit on each pointer to separate full from empty.
// Read data is taken combinationally from the head entry; flush drops all contents.
module axis_sync_fifo
  import quad_align_pkg::*;
#(
  parameter int WIDTH = 257,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // A write at full is refused even if a pop happens in the same cycle.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_quad_aligner.sv
// Buffers four AXI-Stream channels and releases one beat only when all four have data.
// Optional skew timeout/flush is compiled in with `define ALIGN_TIMEOUT_EN.
module axis_quad_aligner
  import quad_align_pkg::*;
#(
  parameter int DATA_WIDTH     = CH_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH-1:0]   s2_axis_tdata,
  input  logic [DATA_WIDTH-1:0]   s3_axis_tdata,
  input  logic                    s0_axis_tvalid,
  input  logic                    s1_axis_tvalid,
  input  logic                    s2_axis_tvalid,
  input  logic                    s3_axis_tvalid,
  input  logic                    s0_axis_tlast,
  input  logic                    s1_axis_tlast,
  input  logic                    s2_axis_tlast,
  input  logic                    s3_axis_tlast,
  output logic                    s0_axis_tready,
  output logic                    s1_axis_tready,
  output logic                    s2_axis_tready,
  output logic                    s3_axis_tready,
  output logic [4*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    last_err,
  output logic                    timeout_err
);

  logic [NUM_CH-1:0]          s_tvalid;
  logic [NUM_CH-1:0]          s_tlast;
  logic [NUM_CH-1:0]          s_tready;
  logic [NUM_CH-1:0]          full;
  logic [NUM_CH-1:0]          empty;
  logic [DATA_WIDTH-1:0]      s_tdata [NUM_CH];
  ch_beat_t                   rd_beat [NUM_CH];
  logic [NUM_CH-1:0]          popped_last;
  logic [4*DATA_WIDTH-1:0]    popped_data;
  logic                       all_avail;
  logic                       load;
  logic                       fifo_flush;

  assign s_tvalid   = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
  assign s_tlast    = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};
  assign s_tdata[0] = s0_axis_tdata;
  assign s_tdata[1] = s1_axis_tdata;
  assign s_tdata[2] = s2_axis_tdata;
  assign s_tdata[3] = s3_axis_tdata;
  assign {s3_axis_tready, s2_axis_tready, s1_axis_tready, s0_axis_tready} = s_tready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_beat_t wr_beat;

    assign wr_beat.tlast = s_tlast[i];
    assign wr_beat.tdata = s_tdata[i];
    // Ready is held low while reset is asserted so nothing is accepted in the reset cycle.
    assign s_tready[i]   = resetn & ~full[i];

    axis_sync_fifo #(
      .WIDTH ($bits(ch_beat_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .resetn  (resetn),
      .flush   (fifo_flush),
      .wr_en   (s_tvalid[i] & s_tready[i]),
      .wr_data (wr_beat),
      .rd_en   (load),
      .rd_data (rd_beat[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  assign all_avail = &(~empty);
  assign load      = all_avail & (~m_axis_tvalid | m_axis_tready);

  always_comb begin
    popped_last = '0;
    popped_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      popped_last[i]                              = rd_beat[i].tlast;
      popped_data[i*DATA_WIDTH +: DATA_WIDTH]     = rd_beat[i].tdata;
    end
  end

  // One output stage: refilled on every load, otherwise drained by downstream ready.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      last_err      <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= popped_data;
        m_axis_tlast  <= |popped_last;
        if ((|popped_last) && !(&popped_last)) last_err <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef ALIGN_TIMEOUT_EN
  localparam int SKEW_W = clog2(TIMEOUT_CYCLES) + 1;

  logic [SKEW_W-1:0] skew_cnt;
  logic              skew_hit;
  logic              partial;
  logic              timeout_q;

  assign partial     = (|(~empty)) & ~all_avail & ~load;
  assign skew_hit    = (skew_cnt == SKEW_W'(TIMEOUT_CYCLES - 1));
  assign fifo_flush  = skew_hit;
  assign timeout_err = timeout_q;

  // The flush only empties the FIFOs; a beat already in the output stage is kept.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      skew_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (skew_hit) begin
      skew_cnt  <= '0;
      timeout_q <= 1'b1;
    end else if (partial) begin
      skew_cnt  <= skew_cnt + SKEW_W'(1);
    end else begin
      skew_cnt  <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign fifo_flush         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_axis_quad_aligner.sv
// Directed bench for axis_quad_aligner with a scoreboard of expected aligned beats.
// Define ALIGN_TIMEOUT_EN for both bench and RTL to exercise the skew timeout.
module tb_axis_quad_aligner;
  import quad_align_pkg::*;

  localparam int DW    = 256;
  localparam int DEPTH = 8;
`ifdef ALIGN_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s_tdata [4];
  logic [3:0]    s_tvalid;
  logic [3:0]    s_tlast;
  logic [3:0]    s_tready;
  logic [4*DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          last_err;
  logic          timeout_err;

  typedef struct {
    logic [4*DW-1:0] data;
    logic            last;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   acc [4];
  int   last_at [4];
  int   nformed;
  int   nbeats;
  int   beat_base;
  int   out_cnt;
  logic cum_err;
  logic held_valid;
  logic [4*DW-1:0] held_data;
  logic held_last;
  int   checks;
  int   failures;

  always #5 CLK = ~CLK;

  axis_quad_aligner #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK            (CLK),
    .resetn         (resetn),
    .s0_axis_tdata  (s_tdata[0]),
    .s1_axis_tdata  (s_tdata[1]),
    .s2_axis_tdata  (s_tdata[2]),
    .s3_axis_tdata  (s_tdata[3]),
    .s0_axis_tvalid (s_tvalid[0]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s2_axis_tvalid (s_tvalid[2]),
    .s3_axis_tvalid (s_tvalid[3]),
    .s0_axis_tlast  (s_tlast[0]),
    .s1_axis_tlast  (s_tlast[1]),
    .s2_axis_tlast  (s_tlast[2]),
    .s3_axis_tlast  (s_tlast[3]),
    .s0_axis_tready (s_tready[0]),
    .s1_axis_tready (s_tready[1]),
    .s2_axis_tready (s_tready[2]),
    .s3_axis_tready (s_tready[3]),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .last_err       (last_err),
    .timeout_err    (timeout_err)
  );

  function automatic logic [DW-1:0] beat_data(input int ch, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'(ch*100 + b + beat_base);
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Once every channel has accepted beat n, beat n is the next aligned output.
  task automatic form_expected();
    exp_t e;
    logic [3:0] lasts;
    while (acc[0] > nformed && acc[1] > nformed && acc[2] > nformed && acc[3] > nformed) begin
      for (int i = 0; i < 4; i++) begin
        e.data[i*DW +: DW] = beat_data(i, nformed);
        lasts[i] = (nformed == last_at[i]);
      end
      e.last = |lasts;
      if ((|lasts) && !(&lasts)) cum_err = 1'b1;
      e.err = cum_err;
      sb.push_back(e);
      nformed++;
    end
  endtask

  // mode 0: downstream always ready, 1: ready toggles each cycle, 2: ready held low
  task automatic applyStimulus(input int ncycles, input logic [3:0] en, input int mode);
    for (int c = 0; c < ncycles; c++) begin
      @(posedge CLK);
      #1;
      m_axis_tready = (mode == 1) ? ~m_axis_tready : (mode == 0);
      for (int i = 0; i < 4; i++) begin
        s_tvalid[i] = en[i] && (acc[i] < nbeats);
        s_tdata[i]  = beat_data(i, acc[i]);
        s_tlast[i]  = s_tvalid[i] && (acc[i] == last_at[i]);
      end
      @(negedge CLK);
      #1;
      for (int i = 0; i < 4; i++) if (s_tvalid[i] && s_tready[i]) acc[i]++;
      form_expected();
    end
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1;
    resetn   = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    @(negedge CLK);
    #1;
    checkOutput("ready_in_reset_cycle", DW'(s_tready), DW'(0));
    @(negedge CLK);
    #1;
    checkOutput("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("rst_tlast", DW'(m_axis_tlast), DW'(0));
    checkOutput("rst_tdata_lo", m_axis_tdata[DW-1:0], '0);
    checkOutput("rst_tdata_hi", m_axis_tdata[4*DW-1:3*DW], '0);
    checkOutput("rst_last_err", DW'(last_err), DW'(0));
    checkOutput("rst_timeout_err", DW'(timeout_err), DW'(0));
    checkOutput("rst_ready_low", DW'(s_tready), DW'(0));
    for (int i = 0; i < 4; i++) begin
      acc[i]     = 0;
      last_at[i] = -1;
    end
    nformed    = 0;
    out_cnt    = 0;
    cum_err    = 1'b0;
    held_valid = 1'b0;
    sb.delete();
    @(posedge CLK);
    #1;
    resetn = 1'b1;
    @(negedge CLK);
    #1;
    checkOutput("ready_after_reset", DW'(s_tready), DW'(4'hf));
  endtask

  task automatic waitDrain(input string tag, input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < limit) begin
      applyStimulus(1, 4'h0, 0);
      n++;
    end
    checkOutput({tag, "_drain_left"}, DW'(sb.size()), DW'(0));
  endtask

  // Output monitor: compares each accepted output beat against the scoreboard head.
  always @(negedge CLK) begin
    if (resetn) begin
      if (held_valid) begin
        checkOutput("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
        for (int i = 0; i < 4; i++)
          checkOutput($sformatf("hold_data_ch%0d", i), m_axis_tdata[i*DW +: DW], held_data[i*DW +: DW]);
        checkOutput("hold_tlast", DW'(m_axis_tlast), DW'(held_last));
      end
      held_valid = m_axis_tvalid && !m_axis_tready;
      held_data  = m_axis_tdata;
      held_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", DW'(1), DW'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int i = 0; i < 4; i++)
            checkOutput($sformatf("beat%0d_ch%0d", out_cnt, i), m_axis_tdata[i*DW +: DW], e.data[i*DW +: DW]);
          checkOutput($sformatf("beat%0d_tlast", out_cnt), DW'(m_axis_tlast), DW'(e.last));
          checkOutput($sformatf("beat%0d_last_err", out_cnt), DW'(last_err), DW'(e.err));
        end
        out_cnt++;
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    s_tvalid      = '0;
    s_tlast       = '0;
    m_axis_tready = 1'b1;
    beat_base     = 0;
    nbeats        = 20;
    for (int i = 0; i < 4; i++) s_tdata[i] = '0;

    $display("[TB] reset and aligned stream");
    doReset();
    nbeats = 20;
    applyStimulus(1, 4'hf, 0);
    checkOutput("latency_before_push", DW'(m_axis_tvalid), DW'(0));
    applyStimulus(1, 4'hf, 0);
    checkOutput("latency_one_edge", DW'(m_axis_tvalid), DW'(0));
    applyStimulus(1, 4'hf, 0);
    checkOutput("latency_two_edges", DW'(m_axis_tvalid), DW'(1));
    applyStimulus(17, 4'hf, 0);
    applyStimulus(2, 4'h0, 0);
    checkOutput("throughput_count", DW'(out_cnt), DW'(20));
    waitDrain("aligned", 20);

    $display("[TB] skewed channel 3");
    doReset();
    nbeats = 20;
    applyStimulus(12, 4'b0111, 0);
    checkOutput("skew_ready", DW'(s_tready), DW'(4'b1000));
    checkOutput("skew_no_output", DW'(m_axis_tvalid), DW'(0));
    checkOutput("skew_acc_ch0", DW'(acc[0]), DW'(DEPTH));
    applyStimulus(40, 4'hf, 0);
    waitDrain("skew", 40);
    checkOutput("skew_count", DW'(out_cnt), DW'(20));

    $display("[TB] output backpressure");
    doReset();
    nbeats = 20;
    applyStimulus(50, 4'hf, 1);
    waitDrain("backpressure", 40);
    checkOutput("bp_count", DW'(out_cnt), DW'(20));

    $display("[TB] tlast misalignment");
    doReset();
    nbeats  = 6;
    last_at = '{4, 4, 3, 4};
    applyStimulus(8, 4'hf, 0);
    waitDrain("tlast", 20);
    checkOutput("tlast_count", DW'(out_cnt), DW'(6));
    checkOutput("tlast_err_sticky", DW'(last_err), DW'(1));

    $display("[TB] reset mid-stream");
    doReset();
    nbeats = 3;
    applyStimulus(4, 4'hf, 2);
    checkOutput("mid_pushed", DW'(acc[3]), DW'(3));
    doReset();
    applyStimulus(5, 4'h0, 0);
    checkOutput("mid_flushed_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("mid_flushed_count", DW'(out_cnt), DW'(0));
    beat_base = 50;
    nbeats    = 1;
    applyStimulus(1, 4'hf, 0);
    applyStimulus(3, 4'h0, 0);
    checkOutput("mid_first_beat_count", DW'(out_cnt), DW'(1));
    checkOutput("mid_no_timeout", DW'(timeout_err), DW'(0));

`ifdef ALIGN_TIMEOUT_EN
    $display("[TB] skew timeout");
    doReset();
    beat_base = 0;
    nbeats    = 1;
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(10, 4'h0, 0);
    checkOutput("timeout_not_yet", DW'(timeout_err), DW'(0));
    applyStimulus(10, 4'h0, 0);
    checkOutput("timeout_set", DW'(timeout_err), DW'(1));
    checkOutput("timeout_no_output", DW'(m_axis_tvalid), DW'(0));
    acc[0] = 0;
    applyStimulus(1, 4'hf, 0);
    applyStimulus(3, 4'h0, 0);
    checkOutput("timeout_after_count", DW'(out_cnt), DW'(1));
    checkOutput("timeout_sticky", DW'(timeout_err), DW'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
